mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the multicycle CPU's instruction-fetch port and its data (lw/sw) port.
- Replaces the separate instruction and data memories.
- Arbitrates each access and sequences the memory enable, write and read-latency wait.
- Returns a one-cycle acknowledge to the requester, so the control FSM can stall IF/MEM until its access completes.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge bundle between the CPU fetch/data ports, the arbiter
// and the single-port synchronous memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic [1:0]    owner;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy, owner
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch and data ports; all outputs registered.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic             clock,
    input  logic             resetn,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    state_e        state;
    logic          last_d;
    logic [2:0]    cnt;
    logic          grant_d;
    logic          i_ack_r, d_ack_r, m_en_r, m_we_r, busy_r;
    logic [1:0]    owner_r;
    logic [AW-1:0] m_addr_r;
    logic [DW-1:0] m_wdata_r, i_rdata_r, d_rdata_r;

    // Data wins when it is the only requester, or when both request and
    // instruction was granted last.
    assign grant_d = bus.d_req & (~bus.i_req | ~last_d);

    always_ff @(posedge clock) begin
        if (resetn) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            cnt       <= '0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            busy_r    <= 1'b0;
            owner_r   <= '0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
        end else begin
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        last_d    <= grant_d;
                        owner_r   <= grant_d ? 2'd2 : 2'd1;
                        m_en_r    <= 1'b1;
                        m_we_r    <= grant_d & bus.d_we;
                        m_addr_r  <= grant_d ? bus.d_addr : bus.i_addr;
                        m_wdata_r <= grant_d ? bus.d_wdata : '0;
                        busy_r    <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    m_en_r <= 1'b0;
                    m_we_r <= 1'b0;
                    if (m_we_r) begin
                        d_ack_r <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt   <= 3'(LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        if (owner_r == 2'd1) begin
                            i_rdata_r <= bus.m_rdata;
                            i_ack_r   <= 1'b1;
                        end else begin
                            d_rdata_r <= bus.m_rdata;
                            d_ack_r   <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    owner_r <= '0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_ack   = i_ack_r;
    assign bus.i_rdata = i_rdata_r;
    assign bus.d_ack   = d_ack_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.m_en    = m_en_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.busy    = busy_r;
    assign bus.owner   = owner_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=2 and LAT=1), a latency-exact
// memory responder, a transaction-level reference model and directed tests.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        i_req [2];
    logic        d_req [2];
    logic        d_we  [2];
    logic [31:0] i_addr [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];

    logic        o_i_ack [2];
    logic        o_d_ack [2];
    logic        o_m_en  [2];
    logic        o_m_we  [2];
    logic        o_busy  [2];
    logic [1:0]  o_owner [2];
    logic [31:0] o_i_rdata [2];
    logic [31:0] o_d_rdata [2];
    logic [31:0] o_m_addr  [2];
    logic [31:0] o_m_wdata [2];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus0 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) dut0 (.clock(clk), .resetn(resetn), .bus(bus0));
    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (.clock(clk), .resetn(resetn), .bus(bus1));

    assign bus0.i_req = i_req[0];   assign bus1.i_req = i_req[1];
    assign bus0.i_addr = i_addr[0]; assign bus1.i_addr = i_addr[1];
    assign bus0.d_req = d_req[0];   assign bus1.d_req = d_req[1];
    assign bus0.d_we = d_we[0];     assign bus1.d_we = d_we[1];
    assign bus0.d_addr = d_addr[0]; assign bus1.d_addr = d_addr[1];
    assign bus0.d_wdata = d_wdata[0]; assign bus1.d_wdata = d_wdata[1];

    assign o_i_ack[0] = bus0.i_ack;     assign o_i_ack[1] = bus1.i_ack;
    assign o_d_ack[0] = bus0.d_ack;     assign o_d_ack[1] = bus1.d_ack;
    assign o_m_en[0] = bus0.m_en;       assign o_m_en[1] = bus1.m_en;
    assign o_m_we[0] = bus0.m_we;       assign o_m_we[1] = bus1.m_we;
    assign o_busy[0] = bus0.busy;       assign o_busy[1] = bus1.busy;
    assign o_owner[0] = bus0.owner;     assign o_owner[1] = bus1.owner;
    assign o_i_rdata[0] = bus0.i_rdata; assign o_i_rdata[1] = bus1.i_rdata;
    assign o_d_rdata[0] = bus0.d_rdata; assign o_d_rdata[1] = bus1.d_rdata;
    assign o_m_addr[0] = bus0.m_addr;   assign o_m_addr[1] = bus1.m_addr;
    assign o_m_wdata[0] = bus0.m_wdata; assign o_m_wdata[1] = bus1.m_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic int lat_of(input int n);
        return (n == 0) ? 2 : 1;
    endfunction

    // Memory responder: data appears only in the cycle exactly LAT after m_en.
    logic [31:0] mem_x   [logic [32:0]];
    logic [31:0] mdl_mem [logic [32:0]];
    logic        pv [2][8];
    logic [31:0] pd [2][8];

    function automatic logic [31:0] bench_rd(input int n, input logic [31:0] a);
        logic [32:0] key;
        key = {n[0], a};
        return mem_x.exists(key) ? mem_x[key] : a + 32'd1;
    endfunction

    function automatic logic [31:0] mdl_rd(input int n, input logic [31:0] a);
        logic [32:0] key;
        key = {n[0], a};
        return mdl_mem.exists(key) ? mdl_mem[key] : a + 32'd1;
    endfunction

    assign bus0.m_rdata = pv[0][1] ? pd[0][1] : 32'hBAD0BAD0;
    assign bus1.m_rdata = pv[1][0] ? pd[1][0] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            for (int k = 7; k > 0; k--) begin
                pv[n][k] <= pv[n][k-1];
                pd[n][k] <= pd[n][k-1];
            end
            pv[n][0] <= o_m_en[n] && !o_m_we[n];
            pd[n][0] <= bench_rd(n, o_m_addr[n]);
            if (o_m_en[n] && o_m_we[n]) mem_x[{n[0], o_m_addr[n]}] = o_m_wdata[n];
        end
    end

    // Reference model: one transaction at a time, described by its start
    // cycle and the offsets at which strobe and acknowledge must appear.
    int          cyc = 0;
    bit          m_act  [2];
    int          m_t0   [2];
    int          m_kind [2];
    int          m_last [2];
    int          m_doff [2];
    bit          m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] e_ir   [2];
    logic [31:0] e_dr   [2];
    int          mk;
    bit          e_done, e_men, e_busy, gd;
    string       tag;

    always @(negedge clk) begin
        cyc++;
        for (int n = 0; n < 2; n++) begin
            if (resetn) begin
                m_act[n]  = 0;
                m_last[n] = 2;
                e_ir[n]   = '0;
                e_dr[n]   = '0;
            end else begin
                mk     = m_act[n] ? cyc - m_t0[n] : 0;
                e_done = m_act[n] && (mk == m_doff[n]);
                e_men  = m_act[n] && (mk == 1);
                e_busy = m_act[n] && (mk >= 1);
                if (e_done && !m_we[n]) begin
                    if (m_kind[n] == 1) e_ir[n] = m_rd[n];
                    else                e_dr[n] = m_rd[n];
                end
                tag = $sformatf("c%0d u%0d", cyc, n);
                chk({tag, " m_en"},  32'(o_m_en[n]),  32'(e_men));
                chk({tag, " m_we"},  32'(o_m_we[n]),  32'(e_men && m_we[n]));
                chk({tag, " busy"},  32'(o_busy[n]),  32'(e_busy));
                chk({tag, " owner"}, 32'(o_owner[n]), e_busy ? 32'(m_kind[n]) : 32'd0);
                chk({tag, " i_ack"}, 32'(o_i_ack[n]), 32'(e_done && m_kind[n] == 1));
                chk({tag, " d_ack"}, 32'(o_d_ack[n]), 32'(e_done && m_kind[n] == 2));
                chk({tag, " i_rdata"}, o_i_rdata[n], e_ir[n]);
                chk({tag, " d_rdata"}, o_d_rdata[n], e_dr[n]);
                if (e_men) chk({tag, " m_addr"}, o_m_addr[n], m_addr[n]);
                if (e_men && m_we[n]) chk({tag, " m_wdata"}, o_m_wdata[n], m_wd[n]);
                if (e_done) begin
                    m_act[n] = 0;
                end else if (!m_act[n] && (i_req[n] || d_req[n])) begin
                    gd        = d_req[n] && (!i_req[n] || m_last[n] == 1);
                    m_kind[n] = gd ? 2 : 1;
                    m_last[n] = m_kind[n];
                    m_we[n]   = gd && d_we[n];
                    m_addr[n] = gd ? d_addr[n] : i_addr[n];
                    m_wd[n]   = d_wdata[n];
                    m_doff[n] = m_we[n] ? 2 : lat_of(n) + 2;
                    m_rd[n]   = mdl_rd(n, m_addr[n]);
                    if (m_we[n]) mdl_mem[{n[0], m_addr[n]}] = m_wd[n];
                    m_t0[n]   = cyc;
                    m_act[n]  = 1;
                end
            end
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Issue one access and follow it to its ack; offsets count from T0 = 0.
    task automatic txn(input int n, input bit dport, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int ack_at, output int men_at,
                       output int busy_cnt, output int other_acks);
        if (dport) begin
            d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = addr; d_wdata[n] = wdata;
        end else begin
            i_req[n] = 1'b1; i_addr[n] = addr;
        end
        ack_at = -1; men_at = -1; busy_cnt = 0; other_acks = 0;
        for (int c = 0; c < 40 && ack_at < 0; c++) begin
            @(negedge clk);
            if (o_m_en[n] && men_at < 0) men_at = c;
            if (o_busy[n]) busy_cnt++;
            if (dport ? o_d_ack[n] : o_i_ack[n]) ack_at = c;
            if (dport ? o_i_ack[n] : o_d_ack[n]) other_acks++;
        end
        @(posedge clk); #1;
        if (dport) d_req[n] = 1'b0; else i_req[n] = 1'b0;
    endtask

    int a, m, b, o, ia, da, men_cnt;
    int own_seq[$];

    initial begin
        resetn = 1'b1;
        for (int n = 0; n < 2; n++) begin
            i_req[n] = 0; d_req[n] = 0; d_we[n] = 0;
            i_addr[n] = '0; d_addr[n] = '0; d_wdata[n] = '0;
            for (int k = 0; k < 8; k++) begin pv[n][k] = 0; pd[n][k] = '0; end
        end
        idle(3);
        resetn = 1'b0;
        idle(1);

        // 1: instruction read, LAT=2
        txn(0, 0, 0, 32'h40, 32'h0, a, m, b, o);
        chk("t1 ack_at", 32'(a), 32'd4);
        chk("t1 men_at", 32'(m), 32'd1);
        chk("t1 i_rdata", o_i_rdata[0], 32'h41);
        chk("t1 d_acks", 32'(o), 32'd0);
        idle(1);

        // 2: data store
        txn(0, 1, 1, 32'h100, 32'hDEADBEEF, a, m, b, o);
        chk("t2 ack_at", 32'(a), 32'd2);
        chk("t2 men_at", 32'(m), 32'd1);
        chk("t2 busy_cycles", 32'(b), 32'd2);
        chk("t2 mem", mem_x[{1'b0, 32'h100}], 32'hDEADBEEF);
        idle(1);

        // 3: both ports requesting from reset; grants must alternate I, D, ...
        resetn = 1'b1;
        i_req[0] = 1; i_addr[0] = 32'h0;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h200;
        idle(2);
        resetn = 1'b0;
        ia = 0; da = 0;
        for (int c = 0; c < 300 && ia + da < 20; c++) begin
            @(negedge clk);
            if (o_i_ack[0]) begin ia++; own_seq.push_back(int'(o_owner[0])); end
            if (o_d_ack[0]) begin da++; own_seq.push_back(int'(o_owner[0])); end
        end
        @(posedge clk); #1;
        i_req[0] = 0; d_req[0] = 0;
        chk("t3 i_acks", 32'(ia), 32'd10);
        chk("t3 d_acks", 32'(da), 32'd10);
        while (own_seq.size() < 4) own_seq.push_back(-1);
        chk("t3 owner0", 32'(own_seq[0]), 32'd1);
        chk("t3 owner1", 32'(own_seq[1]), 32'd2);
        chk("t3 owner2", 32'(own_seq[2]), 32'd1);
        chk("t3 owner3", 32'(own_seq[3]), 32'd2);
        chk("t3 i_rdata", o_i_rdata[0], 32'h1);
        chk("t3 d_rdata", o_d_rdata[0], 32'h201);
        idle(4);

        // 4: reset during the first WAIT cycle aborts the read
        i_req[0] = 1; i_addr[0] = 32'h80;
        idle(1);
        idle(1);
        resetn = 1'b1; i_req[0] = 0;
        idle(1);
        resetn = 1'b0;
        @(negedge clk);
        chk("t4 busy", 32'(o_busy[0]), 32'd0);
        chk("t4 m_en", 32'(o_m_en[0]), 32'd0);
        chk("t4 owner", 32'(o_owner[0]), 32'd0);
        chk("t4 m_addr", o_m_addr[0], 32'h0);
        chk("t4 i_rdata", o_i_rdata[0], 32'h0);
        ia = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_i_ack[0] || o_d_ack[0]) ia++;
        end
        chk("t4 stray_acks", 32'(ia), 32'd0);
        idle(1);

        // 5: LAT=1 load, then a store must leave d_rdata alone
        mem_x[{1'b1, 32'h300}] = 32'h1234;
        mdl_mem[{1'b1, 32'h300}] = 32'h1234;
        txn(1, 1, 0, 32'h300, 32'h0, a, m, b, o);
        chk("t5 load ack_at", 32'(a), 32'd3);
        chk("t5 d_rdata", o_d_rdata[1], 32'h1234);
        idle(1);
        txn(1, 1, 1, 32'h304, 32'h55, a, m, b, o);
        chk("t5 store ack_at", 32'(a), 32'd2);
        chk("t5 d_rdata kept", o_d_rdata[1], 32'h1234);
        idle(1);

        // 6: one-cycle request pulse still completes exactly once
        i_req[0] = 1; i_addr[0] = 32'h44;
        idle(1);
        i_req[0] = 0;
        men_cnt = 0; ia = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_m_en[0]) men_cnt++;
            if (o_i_ack[0]) ia++;
        end
        chk("t6 m_en pulses", 32'(men_cnt), 32'd1);
        chk("t6 i_ack pulses", 32'(ia), 32'd1);
        chk("t6 busy", 32'(o_busy[0]), 32'd0);
        chk("t6 i_rdata", o_i_rdata[0], 32'h45);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
